// File: rtl/rsa_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : rsa_operand_loader
// Purpose  : Serial operand loader and result unloader wrapped around the RSA
//            modular-arithmetic core: LOAD -> START -> WAIT -> UNLOAD.
// Revision : 1.0
// ============================================================================
module rsa_operand_loader #(
    parameter int WORD_W  = 32,
    parameter int WORDS   = 16,
    parameter int NUM_OPS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_OPS*WORD_W-1:0]       in_data,
    output logic [NUM_OPS*WORD_W*WORDS-1:0] op_data,
    output logic                            core_start,
    input  logic                            core_done,
    input  logic [WORD_W*WORDS-1:0]         core_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_W-1:0]               out_data,
    output logic                            out_last,
    output logic                            busy
);

    localparam int OP_W  = WORD_W * WORDS;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_OPS*OP_W-1:0] op_q, op_d;
    logic [NUM_OPS*OP_W-1:0] op_shift;
    logic [OP_W-1:0]         res_q, res_d;
    logic                    cnt_at_last;

    // Each lane enters at the top of its operand so the first word ends at the LSBs.
    genvar k;
    generate
        for (k = 0; k < NUM_OPS; k = k + 1) begin : g_lane
            assign op_shift[k*OP_W +: OP_W] =
                {in_data[k*WORD_W +: WORD_W], op_q[k*OP_W + WORD_W +: OP_W - WORD_W]};
        end
    endgenerate

    // One counter serves as beat counter in LOAD and word counter in UNLOAD.
    assign cnt_at_last = (cnt_q == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    op_d = op_shift;
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    res_d   = core_result;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    res_d = res_q >> WORD_W;
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_START: begin
                core_start = 1'b1;
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = cnt_at_last;
            end
            default: begin
            end
        endcase
    end

    assign op_data  = op_q;
    assign out_data = res_q[WORD_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_rsa_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_operand_loader
// Purpose  : Randomised, self-checking bench with a job-level reference model.
// Revision : 1.0
// ============================================================================
module tb_rsa_operand_loader;

    localparam int WORD_W  = 32;
    localparam int WORDS   = 16;
    localparam int NUM_OPS = 2;
    localparam int OP_W    = WORD_W * WORDS;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_OPS*WORD_W-1:0] in_data;
    logic [NUM_OPS*OP_W-1:0]   op_data;
    logic                      core_start;
    logic                      core_done;
    logic [OP_W-1:0]           core_result;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_W-1:0]         out_data;
    logic                      out_last;
    logic                      busy;

    rsa_operand_loader #(.WORD_W(WORD_W), .WORDS(WORDS), .NUM_OPS(NUM_OPS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .op_data(op_data), .core_start(core_start),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int n_err = 0;
    int n_checks = 0;

    // Job-level model: beats taken, whether the start cycle has passed, and
    // the queue of result words still owed downstream.
    logic [OP_W-1:0]   m_op [NUM_OPS];
    int                m_beats = 0;
    bit                m_started = 1'b0;
    logic [WORD_W-1:0] m_resq [$];
    int                m_jobs = 0;

    // Per-job observations of the DUT.
    logic [WORD_W-1:0] seen [$];
    int seen_last_cnt, seen_last_idx, dut_beats, stall7;

    // Stimulus knobs.
    int in_mode, out_mode, done_delay, wait_cnt, stall_left;
    bit pat_in, res_pat, spurious, tog;

    function automatic bit m_waiting();
        return m_started && (m_resq.size() == 0);
    endfunction

    function automatic logic [NUM_OPS*OP_W-1:0] m_op_flat();
        logic [NUM_OPS*OP_W-1:0] v;
        for (int k = 0; k < NUM_OPS; k++) v[k*OP_W +: OP_W] = m_op[k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_op(input string name, input logic [NUM_OPS*OP_W-1:0] act,
                          input logic [NUM_OPS*OP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act[255:0], exp[255:0]);
        end
    endtask

    // Reference model and DUT-side monitor, advanced on each rising edge.
    initial forever begin
        @(posedge clk);
        if (!rst && out_valid === 1'b1 && out_ready) begin
            seen.push_back(out_data);
            if (out_last === 1'b1) begin
                seen_last_cnt++;
                seen_last_idx = seen.size() - 1;
            end
        end
        if (!rst && out_valid === 1'b1 && !out_ready && out_data == 32'd7) stall7++;
        if (!rst && in_valid && in_ready === 1'b1) dut_beats++;
        if (rst) begin
            for (int k = 0; k < NUM_OPS; k++) m_op[k] = '0;
            m_beats   = 0;
            m_started = 1'b0;
            m_resq.delete();
        end else if (m_beats < WORDS) begin
            if (in_valid) begin
                for (int k = 0; k < NUM_OPS; k++)
                    m_op[k] = (m_op[k] >> WORD_W)
                            | {in_data[k*WORD_W +: WORD_W], {(OP_W-WORD_W){1'b0}}};
                m_beats++;
            end
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_resq.size() == 0) begin
            if (core_done)
                for (int i = 0; i < WORDS; i++) m_resq.push_back(core_result[i*WORD_W +: WORD_W]);
        end else if (out_ready) begin
            void'(m_resq.pop_front());
            if (m_resq.size() == 0) begin
                m_beats   = 0;
                m_started = 1'b0;
                m_jobs++;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        chk("in_ready",   in_ready,   m_beats < WORDS);
        chk("core_start", core_start, m_beats == WORDS && !m_started);
        chk("busy",       busy,       m_beats >= WORDS);
        chk("out_valid",  out_valid,  m_resq.size() > 0);
        chk("out_last",   out_last,   m_resq.size() == 1);
        if (m_resq.size() > 0) chk("out_data", out_data, m_resq[0]);
        chk_op("op_data", op_data, m_op_flat());
    end

    task automatic drive();
        case (in_mode)
            0:       in_valid = 1'b1;
            1:       begin in_valid = tog; tog = ~tog; end
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        for (int k = 0; k < NUM_OPS; k++)
            in_data[k*WORD_W +: WORD_W] = pat_in ? WORD_W'(32'h1000_0000 * (k + 1) + m_beats)
                                                 : $urandom;
        case (out_mode)
            0: out_ready = 1'b1;
            1: begin
                if (m_resq.size() > 0 && (WORDS - m_resq.size()) == 7 && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (m_waiting()) begin
            wait_cnt++;
            if (wait_cnt == 1)
                for (int i = 0; i < WORDS; i++)
                    core_result[i*WORD_W +: WORD_W] = res_pat ? WORD_W'(i) : $urandom;
            core_done = (wait_cnt >= done_delay);
        end else begin
            wait_cnt  = 0;
            core_done = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            if (spurious)
                for (int i = 0; i < WORDS; i++) core_result[i*WORD_W +: WORD_W] = $urandom;
        end
    endtask

    task automatic run_job(output int start_n);
        int n;
        int j0;
        n = 0;
        j0 = m_jobs;
        start_n = -1;
        seen.delete();
        seen_last_cnt = 0;
        seen_last_idx = -1;
        dut_beats = 0;
        stall7 = 0;
        while (m_jobs == j0 && n < 600) begin
            @(negedge clk);
            n++;
            if (core_start === 1'b1 && start_n < 0) start_n = n;
            drive();
        end
        if (m_jobs == j0) chk("job_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_pattern_job(input int start_n, input bit check_cycle);
        if (check_cycle) chk("start_cycle", 64'(start_n + 1), 64'd17);
        chk("op0_w0",  op_data[31:0],              32'h1000_0000);
        chk("op0_w15", op_data[OP_W-1 -: 32],      32'h1000_000F);
        chk("op1_w0",  op_data[OP_W +: 32],        32'h2000_0000);
        chk("op1_w15", op_data[2*OP_W-1 -: 32],    32'h2000_000F);
        for (int k = 0; k < NUM_OPS; k++)
            for (int i = 0; i < WORDS; i++)
                chk("op_word", op_data[k*OP_W + i*WORD_W +: WORD_W],
                    64'(32'h1000_0000 * (k + 1) + i));
        chk("beats_taken", 64'(dut_beats), 64'd16);
        chk("words_out", 64'(seen.size()), 64'd16);
        for (int i = 0; i < seen.size(); i++) chk("word_seq", seen[i], 64'(i));
        chk("last_count", 64'(seen_last_cnt), 64'd1);
        chk("last_index", 64'(seen_last_idx), 64'd15);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready",  in_ready,   1'b1);
        chk("rst_busy",      busy,       1'b0);
        chk("rst_start",     core_start, 1'b0);
        chk("rst_out_valid", out_valid,  1'b0);
        chk("rst_out_last",  out_last,   1'b0);
        chk_op("rst_op_data", op_data, '0);
    endtask

    initial begin
        int sn;
        int n;
        rst = 1'b1; in_valid = 1'b1; in_data = '0; out_ready = 1'b0;
        core_done = 1'b0; core_result = '0;
        in_mode = 0; out_mode = 0; done_delay = 5; wait_cnt = 0; stall_left = 0;
        pat_in = 1'b1; res_pat = 1'b1; spurious = 1'b0; tog = 1'b1;
        seen_last_cnt = 0; seen_last_idx = -1; dut_beats = 0; stall7 = 0;

        // Beats offered under reset must be ignored.
        repeat (3) begin @(negedge clk); drive(); end
        check_reset_values();

        // Basic load, 5-cycle done latency, free-flowing unload.
        @(negedge clk); rst = 1'b0; drive();
        run_job(sn);
        check_pattern_job(sn, 1'b1);

        // Input back-pressure with alternating valid.
        in_mode = 1; tog = 1'b1; drive();
        run_job(sn);
        check_pattern_job(sn, 1'b0);

        // Output stall of 3 cycles on word 7.
        in_mode = 0; out_mode = 1; stall_left = 3; drive();
        run_job(sn);
        check_pattern_job(sn, 1'b0);
        chk("stall_on_7", 64'(stall7), 64'd3);

        // Spurious core_done during load and start.
        out_mode = 0; spurious = 1'b1; pat_in = 1'b0; res_pat = 1'b0; drive();
        run_job(sn);
        chk("spur_words", 64'(seen.size()), 64'd16);

        // Reset while waiting for the core.
        spurious = 1'b0; done_delay = 30; drive();
        n = 0;
        while (!(m_waiting() && wait_cnt >= 3) && n < 200) begin @(negedge clk); n++; drive(); end
        chk("reach_wait", 64'(m_waiting()), 64'd1);
        rst = 1'b1; drive();
        @(negedge clk);
        check_reset_values();

        // Reset after nine beats, then a full pattern job.
        rst = 1'b0; pat_in = 1'b1; res_pat = 1'b1; done_delay = 5; drive();
        n = 0;
        while (m_beats != 9 && n < 200) begin @(negedge clk); n++; drive(); end
        chk("reach_beat9", 64'(m_beats), 64'd9);
        rst = 1'b1; drive();
        @(negedge clk);
        check_reset_values();
        rst = 1'b0; drive();
        run_job(sn);
        check_pattern_job(sn, 1'b1);

        // Fully randomised jobs.
        for (int j = 0; j < 6; j++) begin
            in_mode = 2; out_mode = 2; spurious = 1'b1; pat_in = 1'b0; res_pat = 1'b0;
            done_delay = $urandom_range(1, 6);
            drive();
            run_job(sn);
            chk("rand_words", 64'(seen.size()), 64'd16);
        end

        repeat (4) begin @(negedge clk); drive(); end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
